// File: rtl/stream_pkg.sv
// Shared types and default widths for the sample streamer.
package stream_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 10;
    localparam int unsigned DefDivW  = 24;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCapt,
        StWait
    } state_e;

endpackage

// File: rtl/pace_timer.sv
// Down-counting pacing timer: load with a period (minimum 3), expires when the count reaches 0.
module pace_timer #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             expire_o
);

    logic [DIV_W-1:0] count_q, count_d;

    // Loading period-1 makes expiry land on the last cycle before the next fetch.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            if (period_i < DIV_W'(3)) begin
                count_d = DIV_W'(2);
            end else begin
                count_d = period_i - DIV_W'(1);
            end
        end else if (count_q != '0) begin
            count_d = count_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == '0);

endmodule

// File: rtl/sample_streamer.sv
// Paced sample-memory reader feeding a shift-register receiver.
// Optional STREAM_LOOP_EN adds a loop_i port for continuous wrap-around streaming.
module sample_streamer
    import stream_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DIV_W  = DefDivW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
`ifdef STREAM_LOOP_EN
    input  logic              loop_i,
`endif
    input  logic              abort_i,
    input  logic [DIV_W-1:0]  period_i,
    input  logic [ADDR_W:0]   length_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              sample_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic [DIV_W-1:0]    period_q, period_d;
    logic [ADDR_W:0]     length_q, length_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                load;
    logic                expire;
    logic                loop_en;
    logic [ADDR_W:0]     next_count;
    logic [DIV_W-1:0]    load_period;

`ifdef STREAM_LOOP_EN
    logic loop_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            loop_q <= 1'b0;
        end else if (state_q == StIdle && start_i && !abort_i) begin
            loop_q <= loop_i;
        end
    end

    assign loop_en = loop_q;
`else
    assign loop_en = 1'b0;
`endif

    assign next_count  = {1'b0, index_q} + (ADDR_W + 1)'(1);
    // The first load happens on the same edge that latches the period.
    assign load_period = (state_q == StIdle) ? period_i : period_q;

    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        period_d       = period_q;
        length_d       = length_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        done_d         = 1'b0;
        load           = 1'b0;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (length_i != '0) begin
                            period_d = period_i;
                            length_d = length_i;
                            index_d  = '0;
                            state_d  = StFetch;
                            load     = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StFetch: begin
                    state_d = StCapt;
                end
                StCapt: begin
                    sample_d       = mem_rdata_i;
                    sample_valid_d = 1'b1;
                    if (next_count < length_q) begin
                        index_d = next_count[ADDR_W-1:0];
                        state_d = StWait;
                    end else begin
                        done_d = 1'b1;
                        if (loop_en) begin
                            index_d = '0;
                            state_d = StWait;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StWait: begin
                    if (expire) begin
                        state_d = StFetch;
                        load    = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            index_q        <= '0;
            period_q       <= '0;
            length_q       <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            period_q       <= period_d;
            length_q       <= length_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    pace_timer #(
        .DIV_W(DIV_W)
    ) u_pace_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load),
        .period_i(load_period),
        .expire_o(expire)
    );

    assign mem_rd_o       = (state_q == StFetch);
    assign mem_addr_o     = index_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule
